// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
//  Module      : riscv_pipe_pkg
//  Description : Shared pipeline constants and scoreboard helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 32;
   localparam int LOAD_LAT_DEF = 1;
   localparam int MUL_LAT_DEF  = 3;
   localparam int CNT_W_DEF    = 2;

   // Larger of two countdown values; WAW must never shorten a pending producer.
   function automatic int max_cnt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_sb_counter.sv
// ============================================================================
//  Module      : sb_counter
//  Description : One scoreboard entry: saturating down-counter with load-max.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter
   import riscv_pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] lat,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_dec;
   logic [CNT_W-1:0] w_next;

   assign w_dec  = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
   assign w_next = load ? CNT_W'(max_cnt(int'(w_dec), int'(lat))) : w_dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_next;
      end
   end

   assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Stall/flush generation from a per-register countdown
//                scoreboard for load-use, multiply and taken-branch hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int LOAD_LAT = LOAD_LAT_DEF,
   parameter int MUL_LAT  = MUL_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteD,
   input  logic [REG_ADDR_W-1:0] RD_D,
   input  logic                  LoadD,
   input  logic                  MulD,
   input  logic [REG_ADDR_W-1:0] RS1_D,
   input  logic [REG_ADDR_W-1:0] RS2_D,
   input  logic                  UseRs1D,
   input  logic                  UseRs2D,
   input  logic                  PCSrcE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic [NUM_REGS-1:0]   PendingMask
);

   localparam logic [CNT_W-1:0] c_load_lat = CNT_W'(LOAD_LAT);
   localparam logic [CNT_W-1:0] c_mul_lat  = CNT_W'(MUL_LAT);

   logic [NUM_REGS-1:0] w_pend;
   logic                w_haz;
   logic                w_issue;
   logic [CNT_W-1:0]    w_lat;

   assign w_haz   = (UseRs1D & w_pend[RS1_D]) | (UseRs2D & w_pend[RS2_D]);
   assign w_issue = RegWriteD & (RD_D != '0) & ~w_haz & ~PCSrcE;
   assign w_lat   = MulD ? c_mul_lat : (LoadD ? c_load_lat : '0);

   // x0 is never tracked so its pending bit is tied low.
   generate
      for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
         if (r == 0) begin : g_zero
            assign w_pend[r] = 1'b0;
         end else begin : g_cnt
            logic [CNT_W-1:0] w_cnt;

            sb_counter #(
               .CNT_W (CNT_W)
            ) u_cnt (
               .clk  (clk),
               .rst  (rst),
               .load (w_issue && (RD_D == REG_ADDR_W'(r))),
               .lat  (w_lat),
               .cnt  (w_cnt)
            );

            assign w_pend[r] = |w_cnt;
         end
      end
   endgenerate

   // Taken branch outranks any data hazard; reset forces everything quiet.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (!rst) begin
         if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (w_haz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   assign PendingMask = rst ? '0 : w_pend;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl with a queue-based
//                scoreboard fed by an independent behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteD, LoadD, MulD, UseRs1D, UseRs2D, PCSrcE;
   logic [4:0]  RD_D, RS1_D, RS2_D;
   logic        StallF, StallD, FlushD, FlushE;
   logic [31:0] PendingMask;

   int          tests  = 0;
   int          failed = 0;

   int          m_cnt [32];
   logic        m_issue;
   logic [4:0]  m_rd;
   int          m_lat;
   logic [35:0] q_exp [$];
   logic [35:0] e;

   wire  [35:0] w_obs = {StallF, StallD, FlushD, FlushE, PendingMask};

   hazard_stall_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteD   (RegWriteD),
      .RD_D        (RD_D),
      .LoadD       (LoadD),
      .MulD        (MulD),
      .RS1_D       (RS1_D),
      .RS2_D       (RS2_D),
      .UseRs1D     (UseRs1D),
      .UseRs2D     (UseRs2D),
      .PCSrcE      (PCSrcE),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .PendingMask (PendingMask)
   );

   always #5 clk = ~clk;

   // Drive one D-stage instruction and push the model's expected outputs.
   task automatic apply(input logic rw, input logic [4:0] rd, input logic ld,
                        input logic mul, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic pc);
      logic        haz;
      logic [31:0] pm;
      logic [3:0]  ctl;
      RegWriteD = rw; RD_D = rd; LoadD = ld; MulD = mul;
      RS1_D = rs1; UseRs1D = u1; RS2_D = rs2; UseRs2D = u2; PCSrcE = pc;
      haz = (u1 && m_cnt[rs1] != 0) || (u2 && m_cnt[rs2] != 0);
      for (int r = 0; r < 32; r++) pm[r] = (m_cnt[r] != 0);
      if (rst)      begin ctl = 4'b0000; pm = '0; end
      else if (pc)  ctl = 4'b0011;
      else if (haz) ctl = 4'b1101;
      else          ctl = 4'b0000;
      q_exp.push_back({ctl, pm});
      m_issue = rw && (rd != 0) && !haz && !pc;
      m_rd    = rd;
      m_lat   = mul ? 3 : (ld ? 1 : 0);
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic advance();
      int dec;
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            dec = (m_cnt[r] == 0) ? 0 : m_cnt[r] - 1;
            if (m_issue && m_rd == 5'(r)) m_cnt[r] = (dec > m_lat) ? dec : m_lat;
            else                          m_cnt[r] = dec;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      @(negedge clk);
      apply(1, 5, 1, 0, 5, 1, 5, 1, 1);
      #1;
      e = q_exp.pop_front(); tests++;
      if (w_obs !== e) begin failed++; $display("FAIL reset_state got %h exp %h", w_obs, e); end
      advance();
      rst = 1'b0;
      idle(); #1;
      e = q_exp.pop_front(); tests++;
      if (w_obs !== 36'h0) begin failed++; $display("FAIL reset_release got %h exp %h", w_obs, 36'h0); end
      advance();
   endtask

   task automatic test_load_use();
      int n = 0;
      apply(1, 5, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e) begin failed++; $display("FAIL lw_issue got %h exp %h", w_obs, e); end
      advance();
      for (int i = 0; i < 8; i++) begin
         apply(1, 6, 0, 0, 5, 1, 1, 1, 0);
         #1; e = q_exp.pop_front(); tests++;
         if (w_obs !== e) begin failed++; $display("FAIL load_use_cyc%0d got %h exp %h", i, w_obs, e); end
         if (!StallF) begin advance(); break; end
         n++;
         advance();
      end
      tests++;
      if (n !== 1) begin failed++; $display("FAIL load_use_stall_cycles got %0d exp 1", n); end
      idle(); #1; e = q_exp.pop_front(); advance();
   endtask

   task automatic test_no_false_stall();
      apply(1, 5, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 6, 0, 0, 7, 1, 8, 1, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || StallF !== 1'b0) begin failed++; $display("FAIL indep_add got %h exp %h", w_obs, e); end
      advance();
      apply(1, 5, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 3, 0, 0, 5, 0, 0, 0, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || StallF !== 1'b0) begin failed++; $display("FAIL lui_unused_rs1 got %h exp %h", w_obs, e); end
      advance();
      idle(); #1; e = q_exp.pop_front(); advance();
   endtask

   task automatic test_mul();
      int n = 0;
      apply(1, 9, 0, 1, 1, 1, 2, 1, 0);
      #1; e = q_exp.pop_front(); advance();
      for (int i = 0; i < 10; i++) begin
         apply(1, 2, 0, 0, 9, 1, 9, 1, 0);
         #1; e = q_exp.pop_front(); tests++;
         if (w_obs !== e) begin failed++; $display("FAIL mul_dep_cyc%0d got %h exp %h", i, w_obs, e); end
         if (!StallF) begin
            tests++;
            if (PendingMask[9] !== 1'b0) begin failed++; $display("FAIL mul_pending9_at_issue got %b exp 0", PendingMask[9]); end
            advance();
            break;
         end
         n++;
         advance();
      end
      tests++;
      if (n !== 3) begin failed++; $display("FAIL mul_stall_cycles got %0d exp 3", n); end
      idle(); #1; e = q_exp.pop_front(); advance();
   endtask

   task automatic test_branch();
      apply(1, 5, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 7, 1, 0, 5, 1, 5, 1, 1);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || {StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
         failed++; $display("FAIL branch_priority got %h exp %h", w_obs, e);
      end
      advance();
      idle(); #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || PendingMask[7] !== 1'b0) begin failed++; $display("FAIL branch_no_write got %h exp %h", w_obs, e); end
      advance();
   endtask

   task automatic test_x0_waw();
      apply(1, 0, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      idle(); #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || PendingMask !== 32'h0) begin failed++; $display("FAIL lw_x0 got %h exp %h", w_obs, e); end
      advance();
      apply(1, 4, 0, 1, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 4, 1, 0, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e) begin failed++; $display("FAIL waw_lw got %h exp %h", w_obs, e); end
      advance();
      for (int i = 0; i < 3; i++) begin
         idle(); #1; e = q_exp.pop_front(); tests++;
         if (w_obs !== e || PendingMask[4] !== (i < 2)) begin
            failed++; $display("FAIL waw_hold_cyc%0d got %h exp %h", i, w_obs, e);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      apply(1, 9, 0, 1, 1, 1, 0, 0, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 2, 0, 0, 9, 1, 9, 1, 0);
      #1; e = q_exp.pop_front(); advance();
      apply(1, 2, 0, 0, 9, 1, 9, 1, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || StallF !== 1'b1) begin failed++; $display("FAIL pre_reset_stall got %h exp %h", w_obs, e); end
      #1 rst = 1'b1;
      #1; tests++;
      if (w_obs !== 36'h0) begin failed++; $display("FAIL async_reset got %h exp %h", w_obs, 36'h0); end
      advance();
      rst = 1'b0;
      apply(1, 2, 0, 0, 9, 1, 9, 1, 0);
      #1; e = q_exp.pop_front(); tests++;
      if (w_obs !== e || StallF !== 1'b0) begin failed++; $display("FAIL post_reset_no_stall got %h exp %h", w_obs, e); end
      advance();
   endtask

   task automatic test_back_to_back();
      logic [4:0] rd, s1, s2;
      for (int i = 0; i < 300; i++) begin
         rd = 5'($urandom_range(0, 7));
         s1 = 5'($urandom_range(0, 7));
         s2 = 5'($urandom_range(0, 7));
         apply(1'($urandom), rd, 1'($urandom), ($urandom_range(0, 3) == 0), s1,
               1'($urandom), s2, 1'($urandom), ($urandom_range(0, 7) == 0));
         #1; e = q_exp.pop_front(); tests++;
         if (w_obs !== e) begin failed++; $display("FAIL random_cyc%0d got %h exp %h", i, w_obs, e); end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_mul();
      test_branch();
      test_x0_waw();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
